// File: rtl/reservation_station_mc_if.sv
// ---------------------------------------------------------------------------
// reservation_station_mc_if
// Bundles the reservation station's issue, CDB wakeup and ALU dispatch
// signals.
//   issue_*  : one renamed instruction per cycle, valid/ready handshake
//   cdb_*    : NUM_CDB result broadcast channels, flattened per channel
//   alu_*    : NUM_ALU dispatch channels, flattened per channel, valid/ready
// Modports:
//   slave  : reservation station side
//   master : issue stage / CDB / ALU bank side (environment)
// ---------------------------------------------------------------------------
interface reservation_station_mc_if #(
    parameter int ROB_WIDTH  = 4,
    parameter int DATA_WIDTH = 32,
    parameter int OP_WIDTH   = 4,
    parameter int NUM_ALU    = 2,
    parameter int NUM_CDB    = 2
);
    logic                            issue_valid;
    logic                            issue_ready;
    logic [OP_WIDTH-1:0]             issue_opcode;
    logic [DATA_WIDTH-1:0]           issue_val1;
    logic [DATA_WIDTH-1:0]           issue_val2;
    logic [ROB_WIDTH-1:0]            issue_tag1;
    logic [ROB_WIDTH-1:0]            issue_tag2;
    logic                            issue_rdy1;
    logic                            issue_rdy2;
    logic [ROB_WIDTH-1:0]            issue_rd_tag;

    logic [NUM_CDB-1:0]              cdb_valid;
    logic [NUM_CDB*ROB_WIDTH-1:0]    cdb_tag;
    logic [NUM_CDB*DATA_WIDTH-1:0]   cdb_value;

    logic [NUM_ALU-1:0]              alu_valid;
    logic [NUM_ALU-1:0]              alu_ready;
    logic [NUM_ALU*OP_WIDTH-1:0]     alu_opcode;
    logic [NUM_ALU*DATA_WIDTH-1:0]   alu_lhs;
    logic [NUM_ALU*DATA_WIDTH-1:0]   alu_rhs;
    logic [NUM_ALU*ROB_WIDTH-1:0]    alu_rd_tag;

    modport slave (
        input  issue_valid, issue_opcode, issue_val1, issue_val2,
               issue_tag1, issue_tag2, issue_rdy1, issue_rdy2, issue_rd_tag,
        output issue_ready,
        input  cdb_valid, cdb_tag, cdb_value,
        output alu_valid, alu_opcode, alu_lhs, alu_rhs, alu_rd_tag,
        input  alu_ready
    );

    modport master (
        output issue_valid, issue_opcode, issue_val1, issue_val2,
               issue_tag1, issue_tag2, issue_rdy1, issue_rdy2, issue_rd_tag,
        input  issue_ready,
        output cdb_valid, cdb_tag, cdb_value,
        input  alu_valid, alu_opcode, alu_lhs, alu_rhs, alu_rd_tag,
        output alu_ready
    );
endinterface

// File: rtl/reservation_station_mc.sv
// ---------------------------------------------------------------------------
// reservation_station_mc
// Buffers RS_SIZE renamed ALU instructions, wakes operands from NUM_CDB
// broadcast channels and dispatches up to NUM_ALU ready entries per cycle,
// oldest first, using an age matrix.
// Ports:
//   clk_in   : clock, rising edge
//   rst_in   : asynchronous active-low reset
//   rdy_in   : global enable, low freezes all state
//   flush_in : synchronous flush, drops every entry and every dispatch
//   bus      : issue / CDB / ALU signals (reservation_station_mc_if.slave)
//   count    : number of busy entries
//   empty    : count == 0
// ---------------------------------------------------------------------------
module reservation_station_mc #(
    parameter int RS_WIDTH   = 3,
    parameter int ROB_WIDTH  = 4,
    parameter int DATA_WIDTH = 32,
    parameter int OP_WIDTH   = 4,
    parameter int NUM_ALU    = 2,
    parameter int NUM_CDB    = 2
) (
    input  logic                   clk_in,
    input  logic                   rst_in,
    input  logic                   rdy_in,
    input  logic                   flush_in,
    reservation_station_mc_if.slave bus,
    output logic [RS_WIDTH:0]      count,
    output logic                   empty
);
    localparam int RS_SIZE = 2 ** RS_WIDTH;
    localparam logic [RS_WIDTH:0] FULL = (RS_WIDTH + 1)'(RS_SIZE);

    // Entry storage
    logic [RS_SIZE-1:0]    busy, rdy1, rdy2;
    logic [OP_WIDTH-1:0]   op_q   [RS_SIZE];
    logic [DATA_WIDTH-1:0] val1_q [RS_SIZE];
    logic [DATA_WIDTH-1:0] val2_q [RS_SIZE];
    logic [ROB_WIDTH-1:0]  tag1_q [RS_SIZE];
    logic [ROB_WIDTH-1:0]  tag2_q [RS_SIZE];
    logic [ROB_WIDTH-1:0]  rd_q   [RS_SIZE];
    // older[a][b] = 1 when entry a was issued before entry b
    logic [RS_SIZE-1:0]    older  [RS_SIZE];

    // Dispatch channel registers
    logic [NUM_ALU-1:0]            alu_valid_q;
    logic [NUM_ALU*OP_WIDTH-1:0]   alu_op_q;
    logic [NUM_ALU*DATA_WIDTH-1:0] alu_lhs_q;
    logic [NUM_ALU*DATA_WIDTH-1:0] alu_rhs_q;
    logic [NUM_ALU*ROB_WIDTH-1:0]  alu_rd_q;

    logic                issue_ready_w;
    logic                issue_fire;
    logic [RS_WIDTH-1:0] free_slot;

    logic                  byp1_hit, byp2_hit;
    logic [DATA_WIDTH-1:0] byp1_val, byp2_val;
    logic [RS_SIZE-1:0]    wake1_hit, wake2_hit;
    logic [DATA_WIDTH-1:0] wake1_val [RS_SIZE];
    logic [DATA_WIDTH-1:0] wake2_val [RS_SIZE];

    logic [NUM_ALU-1:0]    ch_load;
    logic [RS_WIDTH-1:0]   ch_sel [NUM_ALU];
    logic [RS_SIZE-1:0]    disp_mask;
    logic [RS_WIDTH:0]     ndisp;

    assign issue_ready_w   = (count < FULL);
    assign bus.issue_ready = issue_ready_w;
    assign issue_fire      = bus.issue_valid && issue_ready_w;
    assign empty           = (count == '0);

    assign bus.alu_valid  = alu_valid_q;
    assign bus.alu_opcode = alu_op_q;
    assign bus.alu_lhs    = alu_lhs_q;
    assign bus.alu_rhs    = alu_rhs_q;
    assign bus.alu_rd_tag = alu_rd_q;

    // Lowest-index free slot
    always_comb begin
        logic found;
        found     = 1'b0;
        free_slot = '0;
        for (int unsigned i = 0; i < RS_SIZE; i++) begin
            if (!busy[i] && !found) begin
                free_slot = RS_WIDTH'(i);
                found     = 1'b1;
            end
        end
    end

    // CDB match for the issuing instruction and for every stored operand;
    // channels are scanned ascending so the lowest matching channel wins.
    always_comb begin
        byp1_hit  = 1'b0;
        byp2_hit  = 1'b0;
        byp1_val  = '0;
        byp2_val  = '0;
        wake1_hit = '0;
        wake2_hit = '0;
        for (int unsigned i = 0; i < RS_SIZE; i++) begin
            wake1_val[i] = '0;
            wake2_val[i] = '0;
        end
        for (int unsigned k = 0; k < NUM_CDB; k++) begin
            if (bus.cdb_valid[k]) begin
                if (!byp1_hit && bus.cdb_tag[k*ROB_WIDTH +: ROB_WIDTH] == bus.issue_tag1) begin
                    byp1_hit = 1'b1;
                    byp1_val = bus.cdb_value[k*DATA_WIDTH +: DATA_WIDTH];
                end
                if (!byp2_hit && bus.cdb_tag[k*ROB_WIDTH +: ROB_WIDTH] == bus.issue_tag2) begin
                    byp2_hit = 1'b1;
                    byp2_val = bus.cdb_value[k*DATA_WIDTH +: DATA_WIDTH];
                end
                for (int unsigned i = 0; i < RS_SIZE; i++) begin
                    if (!wake1_hit[i] && bus.cdb_tag[k*ROB_WIDTH +: ROB_WIDTH] == tag1_q[i]) begin
                        wake1_hit[i] = 1'b1;
                        wake1_val[i] = bus.cdb_value[k*DATA_WIDTH +: DATA_WIDTH];
                    end
                    if (!wake2_hit[i] && bus.cdb_tag[k*ROB_WIDTH +: ROB_WIDTH] == tag2_q[i]) begin
                        wake2_hit[i] = 1'b1;
                        wake2_val[i] = bus.cdb_value[k*DATA_WIDTH +: DATA_WIDTH];
                    end
                end
            end
        end
    end

    // Oldest-first assignment: each free channel, ascending, takes the
    // eligible entry that no other remaining eligible entry is older than.
    always_comb begin
        logic [RS_SIZE-1:0] remaining;
        logic               found;
        logic               oldest;
        remaining = busy & rdy1 & rdy2;
        disp_mask = '0;
        ch_load   = '0;
        ndisp     = '0;
        found     = 1'b0;
        oldest    = 1'b0;
        for (int unsigned j = 0; j < NUM_ALU; j++) begin
            ch_sel[j] = '0;
        end
        for (int unsigned j = 0; j < NUM_ALU; j++) begin
            if (!alu_valid_q[j] || bus.alu_ready[j]) begin
                found = 1'b0;
                for (int unsigned i = 0; i < RS_SIZE; i++) begin
                    if (remaining[i] && !found) begin
                        oldest = 1'b1;
                        for (int unsigned k = 0; k < RS_SIZE; k++) begin
                            if (remaining[k] && older[k][i]) begin
                                oldest = 1'b0;
                            end
                        end
                        if (oldest) begin
                            found     = 1'b1;
                            ch_sel[j] = RS_WIDTH'(i);
                        end
                    end
                end
                if (found) begin
                    ch_load[j]           = 1'b1;
                    remaining[ch_sel[j]] = 1'b0;
                    disp_mask[ch_sel[j]] = 1'b1;
                    ndisp                = ndisp + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            busy        <= '0;
            rdy1        <= '0;
            rdy2        <= '0;
            count       <= '0;
            alu_valid_q <= '0;
            alu_op_q    <= '0;
            alu_lhs_q   <= '0;
            alu_rhs_q   <= '0;
            alu_rd_q    <= '0;
            for (int unsigned i = 0; i < RS_SIZE; i++) begin
                op_q[i]   <= '0;
                val1_q[i] <= '0;
                val2_q[i] <= '0;
                tag1_q[i] <= '0;
                tag2_q[i] <= '0;
                rd_q[i]   <= '0;
                older[i]  <= '0;
            end
        end else if (rdy_in) begin
            if (flush_in) begin
                busy        <= '0;
                alu_valid_q <= '0;
                count       <= '0;
            end else begin
                // Wakeup only touches operands still waiting
                for (int unsigned i = 0; i < RS_SIZE; i++) begin
                    if (busy[i] && !rdy1[i] && wake1_hit[i]) begin
                        rdy1[i]   <= 1'b1;
                        val1_q[i] <= wake1_val[i];
                    end
                    if (busy[i] && !rdy2[i] && wake2_hit[i]) begin
                        rdy2[i]   <= 1'b1;
                        val2_q[i] <= wake2_val[i];
                    end
                    if (disp_mask[i]) begin
                        busy[i] <= 1'b0;
                    end
                end

                // free_slot is never a slot being dispatched, so a slot
                // freed this edge only becomes usable next cycle.
                if (issue_fire) begin
                    busy[free_slot]   <= 1'b1;
                    op_q[free_slot]   <= bus.issue_opcode;
                    tag1_q[free_slot] <= bus.issue_tag1;
                    tag2_q[free_slot] <= bus.issue_tag2;
                    rd_q[free_slot]   <= bus.issue_rd_tag;
                    rdy1[free_slot]   <= bus.issue_rdy1 || byp1_hit;
                    rdy2[free_slot]   <= bus.issue_rdy2 || byp2_hit;
                    val1_q[free_slot] <= bus.issue_rdy1 ? bus.issue_val1 : byp1_val;
                    val2_q[free_slot] <= bus.issue_rdy2 ? bus.issue_val2 : byp2_val;
                    older[free_slot]  <= '0;
                    for (int unsigned k = 0; k < RS_SIZE; k++) begin
                        if (RS_WIDTH'(k) != free_slot) begin
                            older[k][free_slot] <= 1'b1;
                        end
                    end
                end

                for (int unsigned j = 0; j < NUM_ALU; j++) begin
                    if (ch_load[j]) begin
                        alu_valid_q[j]                          <= 1'b1;
                        alu_op_q[j*OP_WIDTH +: OP_WIDTH]        <= op_q[ch_sel[j]];
                        alu_lhs_q[j*DATA_WIDTH +: DATA_WIDTH]   <= val1_q[ch_sel[j]];
                        alu_rhs_q[j*DATA_WIDTH +: DATA_WIDTH]   <= val2_q[ch_sel[j]];
                        alu_rd_q[j*ROB_WIDTH +: ROB_WIDTH]      <= rd_q[ch_sel[j]];
                    end else if (bus.alu_ready[j]) begin
                        alu_valid_q[j] <= 1'b0;
                    end
                end

                count <= count + (RS_WIDTH + 1)'(issue_fire) - ndisp;
            end
        end
    end
endmodule

// File: tb/tb_reservation_station_mc.sv
// ---------------------------------------------------------------------------
// tb_reservation_station_mc
// Directed stimulus with a scoreboard: every instruction expected to reach
// an ALU is queued in the order the ALU bank should consume it; the monitor
// pops and compares on each handshake (channels ascending within a cycle).
// ---------------------------------------------------------------------------
module tb_reservation_station_mc;
    localparam int RW = 3;
    localparam int TW = 4;
    localparam int DW = 32;
    localparam int OW = 4;
    localparam int NA = 2;
    localparam int NC = 2;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b1;
    logic          rdy   = 1'b1;
    logic          flush = 1'b0;
    logic [RW:0]   count;
    logic          empty;

    reservation_station_mc_if #(
        .ROB_WIDTH(TW), .DATA_WIDTH(DW), .OP_WIDTH(OW), .NUM_ALU(NA), .NUM_CDB(NC)
    ) bus ();

    reservation_station_mc #(
        .RS_WIDTH(RW), .ROB_WIDTH(TW), .DATA_WIDTH(DW), .OP_WIDTH(OW),
        .NUM_ALU(NA), .NUM_CDB(NC)
    ) dut (
        .clk_in  (clk),
        .rst_in  (rst_n),
        .rdy_in  (rdy),
        .flush_in(flush),
        .bus     (bus),
        .count   (count),
        .empty   (empty)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [OW-1:0] op;
        logic [DW-1:0] lhs;
        logic [DW-1:0] rhs;
        logic [TW-1:0] tag;
    } exp_t;

    exp_t sbq[$];
    int   errors = 0;
    int   checks = 0;

    logic [TW-1:0] tag0, tag1;
    logic [DW-1:0] lhs0, lhs1;
    assign tag0 = bus.alu_rd_tag[TW-1:0];
    assign tag1 = bus.alu_rd_tag[2*TW-1:TW];
    assign lhs0 = bus.alu_lhs[DW-1:0];
    assign lhs1 = bus.alu_lhs[2*DW-1:DW];

    task automatic check_eq(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic push(input logic [OW-1:0] op, input logic [DW-1:0] lhs,
                        input logic [DW-1:0] rhs, input logic [TW-1:0] tag);
        exp_t e;
        e.op = op; e.lhs = lhs; e.rhs = rhs; e.tag = tag;
        sbq.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_issue(input logic [OW-1:0] op, input logic [DW-1:0] v1, input logic [DW-1:0] v2,
                            input logic [TW-1:0] t1, input logic [TW-1:0] t2,
                            input logic r1, input logic r2, input logic [TW-1:0] rd);
        bus.issue_valid  = 1'b1;
        bus.issue_opcode = op;
        bus.issue_val1   = v1;
        bus.issue_val2   = v2;
        bus.issue_tag1   = t1;
        bus.issue_tag2   = t2;
        bus.issue_rdy1   = r1;
        bus.issue_rdy2   = r2;
        bus.issue_rd_tag = rd;
        tick();
        bus.issue_valid  = 1'b0;
    endtask

    // Scoreboard monitor: handshakes sampled mid-cycle, fire at next edge
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && rdy && !flush) begin
            for (int j = 0; j < NA; j++) begin
                if (bus.alu_valid[j] && bus.alu_ready[j]) begin
                    check_eq("sb_nonempty", 64'(sbq.size() != 0), 64'd1);
                    if (sbq.size() != 0) begin
                        e = sbq.pop_front();
                        check_eq("sb_op",  64'(bus.alu_opcode[j*OW +: OW]), 64'(e.op));
                        check_eq("sb_lhs", 64'(bus.alu_lhs[j*DW +: DW]),    64'(e.lhs));
                        check_eq("sb_rhs", 64'(bus.alu_rhs[j*DW +: DW]),    64'(e.rhs));
                        check_eq("sb_tag", 64'(bus.alu_rd_tag[j*TW +: TW]), 64'(e.tag));
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.issue_valid = 1'b0; bus.issue_opcode = '0; bus.issue_val1 = '0; bus.issue_val2 = '0;
        bus.issue_tag1 = '0; bus.issue_tag2 = '0; bus.issue_rdy1 = 1'b0; bus.issue_rdy2 = 1'b0;
        bus.issue_rd_tag = '0; bus.cdb_valid = '0; bus.cdb_tag = '0; bus.cdb_value = '0;
        bus.alu_ready = '0;

        // Asynchronous reset mid-cycle, checked before any clock edge
        #2 rst_n = 1'b0;
        #2;
        check_eq("rst_count",       64'(count), 64'd0);
        check_eq("rst_empty",       64'(empty), 64'd1);
        check_eq("rst_issue_ready", 64'(bus.issue_ready), 64'd1);
        check_eq("rst_alu_valid",   64'(bus.alu_valid), 64'd0);
        check_eq("rst_alu_opcode",  64'(bus.alu_opcode), 64'd0);
        check_eq("rst_alu_lhs",     bus.alu_lhs, 64'd0);
        check_eq("rst_alu_rhs",     bus.alu_rhs, 64'd0);
        check_eq("rst_alu_rd_tag",  64'(bus.alu_rd_tag), 64'd0);
        tick();
        tick();
        rst_n = 1'b1;

        // Three ready ops, consecutive edges
        bus.alu_ready = 2'b11;
        push(4'd1, 32'd101, 32'd201, 4'd1);
        do_issue(4'd1, 32'd101, 32'd201, 4'd0, 4'd0, 1'b1, 1'b1, 4'd1);
        check_eq("t1_valid_after_issue", 64'(bus.alu_valid), 64'd0);
        check_eq("t1_count1", 64'(count), 64'd1);
        push(4'd2, 32'd102, 32'd202, 4'd2);
        do_issue(4'd2, 32'd102, 32'd202, 4'd0, 4'd0, 1'b1, 1'b1, 4'd2);
        check_eq("t1_valid_first", 64'(bus.alu_valid), 64'd1);
        check_eq("t1_tag0_first",  64'(tag0), 64'd1);
        check_eq("t1_lhs0_first",  64'(lhs0), 64'd101);
        check_eq("t1_count2",      64'(count), 64'd1);
        push(4'd3, 32'd103, 32'd203, 4'd3);
        do_issue(4'd3, 32'd103, 32'd203, 4'd0, 4'd0, 1'b1, 1'b1, 4'd3);
        check_eq("t1_tag0_second", 64'(tag0), 64'd2);
        tick();
        check_eq("t1_tag0_third", 64'(tag0), 64'd3);
        check_eq("t1_count_zero", 64'(count), 64'd0);
        tick();
        check_eq("t1_valid_idle", 64'(bus.alu_valid), 64'd0);
        check_eq("t1_empty",      64'(empty), 64'd1);

        // Fill all eight entries waiting on tag 5, then one CDB broadcast
        for (int i = 0; i < 8; i++) begin
            push(4'd4, 32'hDEADBEEF, 32'(300 + i), 4'(8 + i));
            do_issue(4'd4, 32'd0, 32'(300 + i), 4'd5, 4'd0, 1'b0, 1'b1, 4'(8 + i));
        end
        check_eq("t2_count_full",  64'(count), 64'd8);
        check_eq("t2_issue_ready", 64'(bus.issue_ready), 64'd0);
        check_eq("t2_valid_wait",  64'(bus.alu_valid), 64'd0);
        do_issue(4'd4, 32'd0, 32'd0, 4'd5, 4'd0, 1'b0, 1'b1, 4'd0);
        check_eq("t2_ninth_ignored", 64'(count), 64'd8);
        bus.cdb_valid = 2'b10;
        bus.cdb_tag   = {4'd5, 4'd0};
        bus.cdb_value = {32'hDEADBEEF, 32'h0};
        tick();
        bus.cdb_valid = '0;
        check_eq("t2_no_same_edge_dispatch", 64'(bus.alu_valid), 64'd0);
        tick();
        check_eq("t2_count6", 64'(count), 64'd6);
        check_eq("t2_valid",  64'(bus.alu_valid), 64'd3);
        check_eq("t2_lhs0",   64'(lhs0), 64'hDEADBEEF);
        check_eq("t2_lhs1",   64'(lhs1), 64'hDEADBEEF);
        check_eq("t2_tag0",   64'(tag0), 64'd8);
        check_eq("t2_tag1",   64'(tag1), 64'd9);
        tick(); tick(); tick();
        check_eq("t2_drained", 64'(count), 64'd0);
        tick();
        check_eq("t2_valid_idle", 64'(bus.alu_valid), 64'd0);

        // Issue bypass with two matching channels: channel 0 wins
        bus.cdb_valid = 2'b11;
        bus.cdb_tag   = {4'd7, 4'd7};
        bus.cdb_value = {32'h22, 32'h11};
        push(4'd5, 32'h11, 32'h55, 4'd4);
        do_issue(4'd5, 32'd0, 32'h55, 4'd7, 4'd0, 1'b0, 1'b1, 4'd4);
        bus.cdb_valid = '0;
        check_eq("t3_count",      64'(count), 64'd1);
        check_eq("t3_valid_none", 64'(bus.alu_valid), 64'd0);
        tick();
        check_eq("t3_valid", 64'(bus.alu_valid), 64'd1);
        check_eq("t3_lhs0",  64'(lhs0), 64'h11);
        tick();
        check_eq("t3_valid_idle", 64'(bus.alu_valid), 64'd0);

        // Back-pressure: A on ALU0, B on ALU1, C waits; ALU0 then takes C
        bus.alu_ready = 2'b00;
        push(4'd6, 32'd1, 32'd2, 4'd1);
        push(4'd6, 32'd5, 32'd6, 4'd3);
        push(4'd6, 32'd3, 32'd4, 4'd2);
        do_issue(4'd6, 32'd1, 32'd2, 4'd0, 4'd0, 1'b1, 1'b1, 4'd1);
        do_issue(4'd6, 32'd3, 32'd4, 4'd0, 4'd0, 1'b1, 1'b1, 4'd2);
        do_issue(4'd6, 32'd5, 32'd6, 4'd0, 4'd0, 1'b1, 1'b1, 4'd3);
        check_eq("t4_valid",  64'(bus.alu_valid), 64'd3);
        check_eq("t4_count",  64'(count), 64'd1);
        tick();
        check_eq("t4_hold_tag0", 64'(tag0), 64'd1);
        check_eq("t4_hold_tag1", 64'(tag1), 64'd2);
        check_eq("t4_hold_lhs0", 64'(lhs0), 64'd1);
        check_eq("t4_hold_lhs1", 64'(lhs1), 64'd3);
        tick();
        check_eq("t4_hold2_tag0",  64'(tag0), 64'd1);
        check_eq("t4_hold2_valid", 64'(bus.alu_valid), 64'd3);
        bus.alu_ready = 2'b01;
        tick();
        bus.alu_ready = 2'b00;
        check_eq("t4_alu0_tag",   64'(tag0), 64'd3);
        check_eq("t4_alu0_lhs",   64'(lhs0), 64'd5);
        check_eq("t4_alu1_tag",   64'(tag1), 64'd2);
        check_eq("t4_alu1_lhs",   64'(lhs1), 64'd3);
        check_eq("t4_valid_both", 64'(bus.alu_valid), 64'd3);
        check_eq("t4_count0",     64'(count), 64'd0);
        bus.alu_ready = 2'b11;
        tick();
        check_eq("t4_valid_idle", 64'(bus.alu_valid), 64'd0);

        // Flush with an issue in the same cycle
        bus.alu_ready = 2'b00;
        do_issue(4'd7, 32'd9, 32'd9, 4'd0, 4'd0, 1'b1, 1'b1, 4'd5);
        for (int i = 0; i < 4; i++) begin
            do_issue(4'd8, 32'd0, 32'(i), 4'd9, 4'd0, 1'b0, 1'b1, 4'(10 + i));
        end
        check_eq("t5_count4", 64'(count), 64'd4);
        check_eq("t5_valid",  64'(bus.alu_valid), 64'd1);
        flush = 1'b1;
        do_issue(4'd9, 32'd1, 32'd1, 4'd0, 4'd0, 1'b1, 1'b1, 4'd15);
        flush = 1'b0;
        check_eq("t5_flush_count", 64'(count), 64'd0);
        check_eq("t5_flush_valid", 64'(bus.alu_valid), 64'd0);
        check_eq("t5_flush_empty", 64'(empty), 64'd1);
        check_eq("t5_issue_ready", 64'(bus.issue_ready), 64'd1);
        bus.alu_ready = 2'b11;
        bus.cdb_valid = 2'b01;
        bus.cdb_tag   = {4'd0, 4'd9};
        bus.cdb_value = '0;
        tick();
        bus.cdb_valid = '0;
        tick(); tick();
        check_eq("t5_dropped_valid", 64'(bus.alu_valid), 64'd0);
        check_eq("t5_dropped_count", 64'(count), 64'd0);

        // Global stall with CDB match, issue request and ALU ready
        bus.alu_ready = 2'b00;
        push(4'd10, 32'hA, 32'hB, 4'd1);
        push(4'd11, 32'h66, 32'hC, 4'd2);
        do_issue(4'd10, 32'hA, 32'hB, 4'd0, 4'd0, 1'b1, 1'b1, 4'd1);
        do_issue(4'd11, 32'd0, 32'hC, 4'd6, 4'd0, 1'b0, 1'b1, 4'd2);
        check_eq("t6_pre_count", 64'(count), 64'd1);
        check_eq("t6_pre_valid", 64'(bus.alu_valid), 64'd1);
        rdy = 1'b0;
        bus.issue_valid  = 1'b1;
        bus.issue_opcode = 4'd12;
        bus.issue_rdy1   = 1'b1;
        bus.issue_rdy2   = 1'b1;
        bus.issue_rd_tag = 4'd3;
        bus.cdb_valid    = 2'b01;
        bus.cdb_tag      = {4'd0, 4'd6};
        bus.cdb_value    = {32'h0, 32'h66};
        bus.alu_ready    = 2'b01;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq("t6_stall_count", 64'(count), 64'd1);
            check_eq("t6_stall_valid", 64'(bus.alu_valid), 64'd1);
            check_eq("t6_stall_tag0",  64'(tag0), 64'd1);
        end
        rdy = 1'b1;
        bus.issue_valid = 1'b0;
        bus.cdb_valid   = '0;
        bus.alu_ready   = 2'b00;
        tick();
        check_eq("t6_resume_count", 64'(count), 64'd1);
        check_eq("t6_resume_valid", 64'(bus.alu_valid), 64'd1);
        bus.alu_ready = 2'b01;
        tick();
        check_eq("t6_not_woken_valid", 64'(bus.alu_valid), 64'd0);
        check_eq("t6_not_woken_count", 64'(count), 64'd1);
        bus.cdb_valid = 2'b01;
        tick();
        bus.cdb_valid = '0;
        check_eq("t6_wake_edge_valid", 64'(bus.alu_valid), 64'd0);
        tick();
        check_eq("t6_disp_valid", 64'(bus.alu_valid), 64'd1);
        check_eq("t6_disp_lhs0",  64'(lhs0), 64'h66);
        check_eq("t6_disp_tag0",  64'(tag0), 64'd2);
        check_eq("t6_disp_count", 64'(count), 64'd0);
        tick();
        check_eq("t6_valid_idle", 64'(bus.alu_valid), 64'd0);

        check_eq("sb_drained", 64'(sbq.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/reservation_station_mc.md
Name: reservation_station_mc

Overview:
Parametrised, multi-channel successor to the single-issue ALU reservation station.
- Buffers RS_SIZE renamed ALU instructions and snoops NUM_CDB result broadcast channels for operand wakeup.
- Dispatches up to NUM_ALU ready instructions per cycle, oldest-first, over valid/ready handshakes.
- Supports a pipeline flush on branch mispredict. Sits between the issue stage / register file and the ALU bank.

Parameters:
RS_WIDTH, 3, log2 of entry count; RS_SIZE = 2**RS_WIDTH
ROB_WIDTH, 4, ROB tag width
DATA_WIDTH, 32, operand width
OP_WIDTH, 4, ALU opcode width
NUM_ALU, 2, dispatch channels (1..4)
NUM_CDB, 2, broadcast/wakeup channels (1..4)

Ports:
clk_in  in  1  clock, all state updates on rising edge
rst_in  in  1  reset; asynchronous, active-low
rdy_in  in  1  global stall; low freezes all state
flush_in  in  1  synchronous flush (mispredict)
issue_valid  in  1  issue request
issue_ready  out  1  RS can accept (not full)
issue_opcode  in  OP_WIDTH  ALU op
issue_val1, issue_val2  in  DATA_WIDTH each  operand values
issue_tag1, issue_tag2  in  ROB_WIDTH each  producer tags
issue_rdy1, issue_rdy2  in  1 each  operand value valid
issue_rd_tag  in  ROB_WIDTH  destination ROB tag
cdb_valid  in  NUM_CDB  broadcast valid per channel
cdb_tag  in  NUM_CDB*ROB_WIDTH  broadcast tags, channel k at [k*ROB_WIDTH +: ROB_WIDTH]
cdb_value  in  NUM_CDB*DATA_WIDTH  broadcast values
alu_valid  out  NUM_ALU  dispatch valid per ALU
alu_ready  in  NUM_ALU  ALU accepts
alu_opcode  out  NUM_ALU*OP_WIDTH  dispatched opcode
alu_lhs, alu_rhs  out  NUM_ALU*DATA_WIDTH each  operands
alu_rd_tag  out  NUM_ALU*ROB_WIDTH  destination tag
count  out  RS_WIDTH+1  busy entries
empty  out  1  count==0

Behaviour:
Reset:
- rst_in low, asynchronously: all entries not busy; alu_valid=0; alu_opcode/lhs/rhs/rd_tag=0; count=0; age state cleared.
- Outputs at reset: issue_ready=1, empty=1.

Stall and flush:
- rdy_in low: no state changes. Outputs hold. No issue is accepted, even if issue_valid=1.
- flush_in=1 with rdy_in=1: at the edge, all busy and alu_valid clear and count becomes 0. Overrides issue, wakeup and dispatch in the same cycle.

Issue:
- Accepted when issue_valid & issue_ready & rdy_in. issue_ready = (count < RS_SIZE), computed from pre-edge state.
- A slot freed by dispatch at the same edge is reusable from the next cycle only.
- The entry is written to the lowest-index free slot and marked youngest.
- Issue bypass: if issue_rdyN=0 and some cdb_valid[k] has cdb_tag[k]==issue_tagN in the same cycle, the operand is stored valid with cdb_value[k].

Wakeup:
- Each busy entry, per operand not yet valid: a matching valid CDB sets the operand valid and captures the value.
- Multiple matching channels: lowest k wins.
- Valid operands are never overwritten.

Dispatch:
- An entry is eligible when busy and both operands valid in pre-edge state. There is no wakeup-to-dispatch bypass within a cycle.
- Channel j is free when alu_valid[j]=0 or alu_ready[j]=1.
- Free channels, in ascending j, receive the eligible entries in age order: oldest to the lowest free j.
- Age is tracked by an RS_SIZE x RS_SIZE age matrix.
- A dispatched entry is freed at the same edge, and its payload registers onto channel j with alu_valid[j]=1.
- Channel j with no eligible entry left: alu_valid[j] goes to 0 if consumed, otherwise holds.
- Handshake: while alu_valid[j]=1 and alu_ready[j]=0, the payload is stable.

Latency:
- Issue with both operands ready at edge E: alu_valid at E+1.
- CDB wakeup at edge E: dispatch at E+1.

Counting:
- count update per edge: +1 on accepted issue, minus the number of dispatched entries.
- count never exceeds RS_SIZE and never underflows.

Test Plan:
- Reset with rst_in low mid-cycle, then issue 3 ready ops tags 1,2,3 at consecutive edges, alu_ready=11 -> alu_valid immediately 0; tag1 on ALU0 one edge after its issue; tags 2,3 follow in order; count returns to 0.
- Fill 8 entries with issue_rdy1=0 (tag 5) -> issue_ready=0 at count=8; the 9th request is ignored. Broadcast cdb tag 5, value 0xDEADBEEF on channel 1 -> next edge ALU0/ALU1 get the two oldest, lhs=0xDEADBEEF; count=6.
- Issue an op waiting on tag 7 while cdb_valid[0], tag 7, value 0x11 is in the same cycle -> entry stored ready; dispatched next edge with lhs=0x11.
- alu_ready=00 with 3 ready entries -> alu_valid=11 holds with stable payloads; raise alu_ready[0] for one cycle -> ALU0 takes the third (oldest remaining) entry, ALU1 unchanged.
- Issue and flush_in in the same cycle with 4 busy entries -> count=0, alu_valid=00, the issued op is dropped.
- rdy_in=0 for 3 cycles with a CDB match and issue_valid=1 -> no state change; after rdy_in rises, behaviour resumes from the frozen state.
